blackjack_states_ctrl: RTL and testbench

- Single-player blackjack game controller (player vs dealer).
- Waits for the deck to report shuffled, then deals cards from an external card source.
- Runs player hit/stay decisions, then dealer auto-play, and flags the outcome.
- Sits between the deck/shuffle memory block and the UI/display logic.

---
 rtl/blackjack_pkg.sv | 44 ++++
 rtl/blackjack_hand.sv | 39 +++
 rtl/blackjack_states_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_blackjack_states_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types and helpers for the blackjack controller: FSM states, action
// codes, card code constants and hand-total arithmetic.
package blackjack_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    CHECK_NAT,
    PLAYER_TURN,
    PLAYER_HIT,
    DEALER_TURN,
    DEALER_HIT,
    COMPARE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HIT  = 2'd1,
    STAY = 2'd2,
    BUST = 2'd3
  } action_e;

  localparam logic [4:0] ACE       = 5'd1;
  localparam logic [4:0] FACE      = 5'd11;
  localparam logic [4:0] BLACKJACK = 5'd21;

  function automatic logic card_valid(input logic [4:0] code);
    return (code >= ACE) && (code <= FACE);
  endfunction

  function automatic logic [4:0] card_value(input logic [4:0] code);
    return (code == FACE) ? 5'd10 : code;
  endfunction

  // One ace is promoted to 11 only while that keeps the hand at or under 21.
  function automatic logic [4:0] best_total(input logic [4:0] sum_hard, input logic has_ace);
    return (has_ace && (sum_hard <= 5'd11)) ? (sum_hard + 5'd10) : sum_hard;
  endfunction

endpackage

// File: rtl/blackjack_hand.sv
// One blackjack hand: accumulates card codes as a hard sum plus an ace flag
// and reports the best total and a bust flag. Synchronous clear.
module blackjack_hand
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [4:0] card_i,
  output logic [4:0] best_o,
  output logic       bust_o
);

  logic [4:0] sum_q, sum_d;
  logic       ace_q, ace_d;

  always_comb begin
    sum_d = sum_q + card_value(card_i);
    ace_d = ace_q | (card_i == ACE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ace_q <= 1'b0;
    end else if (clear_i) begin
      sum_q <= '0;
      ace_q <= 1'b0;
    end else if (add_i) begin
      sum_q <= sum_d;
      ace_q <= ace_d;
    end
  end

  assign best_o = best_total(sum_q, ace_q);
  assign bust_o = (best_o > BLACKJACK);

endmodule

// File: rtl/blackjack_states_ctrl.sv
// Single-player blackjack game controller. Optional idle auto-stay in the
// player turn is enabled by defining BLACKJACK_AUTO_STAY_EN.
module blackjack_states_ctrl
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = 17
`ifdef BLACKJACK_AUTO_STAY_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       stay,
  input  logic       shuffle_ok,
  input  logic [4:0] card_in,
  output logic       card_ctrl,
  output logic       mem_ctrl_rd,
  output logic       mem_ctrl_wr,
  output logic [4:0] card_out,
  output logic [4:0] player_hand,
  output logic [4:0] dealer_hand,
  output logic [1:0] player_action,
  output logic [1:0] dealer_action,
  output logic       win,
  output logic       lose,
  output logic       tie,
  output state_e     state_o
);

  localparam logic [4:0] STAND_T = 5'(DEALER_STAND);

  state_e     state_q;
  logic       eval_q;
  logic [4:0] card_out_q;
  action_e    p_act_q, d_act_q;
  logic       win_q, lose_q, tie_q, wr_q;

  logic       fetch, valid, take, p_add, d_add, clr, timeout;
  logic [4:0] p_best, d_best;
  logic       p_bust, d_bust;

  // Fetch card handshake: card_ctrl/mem_ctrl_rd high for one cycle means the
  // source must present card_in before the closing rising edge; a code outside
  // 1..11 is dropped and the request simply stays up for another cycle.
  // Hit states split into a fetch phase and an evaluate phase (eval_q) so the
  // decision uses the registered, already-updated hand total.
  always_comb begin
    fetch = 1'b0;
    case (state_q)
      DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2: fetch = 1'b1;
      PLAYER_HIT, DEALER_HIT:             fetch = !eval_q;
      default:                            fetch = 1'b0;
    endcase
  end

  assign valid = card_valid(card_in);
  assign take  = fetch && valid;
  assign p_add = take && (state_q inside {DEAL_P1, DEAL_P2, PLAYER_HIT});
  assign d_add = take && (state_q inside {DEAL_D1, DEAL_D2, DEALER_HIT});
  assign clr   = shuffle_ok && (state_q inside {IDLE, DONE});

  blackjack_hand u_player (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clr),
    .add_i   (p_add),
    .card_i  (card_in),
    .best_o  (p_best),
    .bust_o  (p_bust)
  );

  blackjack_hand u_dealer (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clr),
    .add_i   (d_add),
    .card_i  (card_in),
    .best_o  (d_best),
    .bust_o  (d_bust)
  );

`ifdef BLACKJACK_AUTO_STAY_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt_q;

  assign timeout = (state_q == PLAYER_TURN) && !hit && !stay &&
                   (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else if ((state_q == PLAYER_TURN) && !hit && !stay && !timeout) begin
      idle_cnt_q <= idle_cnt_q + CW'(1);
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      eval_q     <= 1'b0;
      card_out_q <= '0;
      p_act_q    <= NONE;
      d_act_q    <= NONE;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      tie_q      <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (take) card_out_q <= card_in;
      case (state_q)
        IDLE, DONE: begin
          if (shuffle_ok) begin
            state_q <= DEAL_P1;
            p_act_q <= NONE;
            d_act_q <= NONE;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            tie_q   <= 1'b0;
          end
        end
        DEAL_P1: if (valid) state_q <= DEAL_D1;
        DEAL_D1: if (valid) state_q <= DEAL_P2;
        DEAL_P2: if (valid) state_q <= DEAL_D2;
        DEAL_D2: if (valid) state_q <= CHECK_NAT;
        CHECK_NAT: begin
          if ((p_best == BLACKJACK) || (d_best == BLACKJACK)) begin
            state_q <= DONE;
            wr_q    <= 1'b1;
            tie_q   <= (p_best == BLACKJACK) && (d_best == BLACKJACK);
            win_q   <= (p_best == BLACKJACK) && (d_best != BLACKJACK);
            lose_q  <= (p_best != BLACKJACK) && (d_best == BLACKJACK);
          end else begin
            state_q <= PLAYER_TURN;
          end
        end
        PLAYER_TURN: begin
          if (stay || timeout) begin
            p_act_q <= STAY;
            state_q <= DEALER_TURN;
          end else if (hit) begin
            p_act_q <= HIT;
            state_q <= PLAYER_HIT;
          end
        end
        PLAYER_HIT: begin
          if (!eval_q) begin
            if (valid) eval_q <= 1'b1;
          end else begin
            eval_q <= 1'b0;
            if (p_bust) begin
              p_act_q <= BUST;
              lose_q  <= 1'b1;
              wr_q    <= 1'b1;
              state_q <= DONE;
            end else if (p_best == BLACKJACK) begin
              p_act_q <= STAY;
              state_q <= DEALER_TURN;
            end else begin
              state_q <= PLAYER_TURN;
            end
          end
        end
        DEALER_TURN: begin
          if (d_best < STAND_T) begin
            d_act_q <= HIT;
            state_q <= DEALER_HIT;
          end else begin
            d_act_q <= STAY;
            state_q <= COMPARE;
          end
        end
        DEALER_HIT: begin
          if (!eval_q) begin
            if (valid) eval_q <= 1'b1;
          end else begin
            eval_q <= 1'b0;
            if (d_bust) begin
              d_act_q <= BUST;
              win_q   <= 1'b1;
              wr_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= DEALER_TURN;
            end
          end
        end
        COMPARE: begin
          win_q   <= (p_best > d_best);
          lose_q  <= (p_best < d_best);
          tie_q   <= (p_best == d_best);
          wr_q    <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign card_ctrl     = fetch;
  assign mem_ctrl_rd   = fetch;
  assign mem_ctrl_wr   = wr_q;
  assign card_out      = card_out_q;
  assign player_hand   = p_best;
  assign dealer_hand   = d_best;
  assign player_action = p_act_q;
  assign dealer_action = d_act_q;
  assign win           = win_q;
  assign lose          = lose_q;
  assign tie           = tie_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_blackjack_states_ctrl.sv
// Directed self-checking bench for blackjack_states_ctrl: deals fixed card
// sequences and checks hands, actions, outcome flags and fetch strobes.
module tb_blackjack_states_ctrl;
  import blackjack_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hit = 1'b0;
  logic       stay = 1'b0;
  logic       shuffle_ok = 1'b0;
  logic [4:0] card_in = 5'd0;
  logic       card_ctrl, mem_ctrl_rd, mem_ctrl_wr;
  logic [4:0] card_out, player_hand, dealer_hand;
  logic [1:0] player_action, dealer_action;
  logic       win, lose, tie;
  state_e     state_o;

  int vectors = 0;
  int miscompares = 0;
  int card_cnt = 0;
  int wr_cnt = 0;

  blackjack_states_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .hit           (hit),
    .stay          (stay),
    .shuffle_ok    (shuffle_ok),
    .card_in       (card_in),
    .card_ctrl     (card_ctrl),
    .mem_ctrl_rd   (mem_ctrl_rd),
    .mem_ctrl_wr   (mem_ctrl_wr),
    .card_out      (card_out),
    .player_hand   (player_hand),
    .dealer_hand   (dealer_hand),
    .player_action (player_action),
    .dealer_action (dealer_action),
    .win           (win),
    .lose          (lose),
    .tie           (tie),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (card_ctrl === 1'b1) card_cnt++;
    if (mem_ctrl_wr === 1'b1) wr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    shuffle_ok = 1'b1;
    tick();
    shuffle_ok = 1'b0;
  endtask

  task automatic deal(input logic [4:0] c);
    int n = 0;
    card_in = c;
    while (card_ctrl !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    vectors++;
    if (card_ctrl !== 1'b1) begin
      miscompares++;
      $display("FAIL deal_wait: card_ctrl=%b required 1 (card %0d)", card_ctrl, c);
    end else begin
      tick();
    end
  endtask

  task automatic wait_state(input state_e s, input string tag);
    int n = 0;
    while (state_o !== s && n < 64) begin
      tick();
      n++;
    end
    vectors++;
    if (state_o !== s) begin
      miscompares++;
      $display("FAIL %s: state=%0d required %0d", tag, state_o, s);
    end
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    int c0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    c0 = card_cnt;
    repeat (4) tick();
    outs = {card_ctrl, mem_ctrl_rd, mem_ctrl_wr, card_out, player_hand, dealer_hand,
            player_action, dealer_action, win, lose, tie};
    vectors++;
    if (state_o !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d required %0d", state_o, IDLE);
    end
    vectors++;
    if (outs !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: outs=%h required 0", outs);
    end
    vectors++;
    if (card_cnt - c0 != 0) begin
      miscompares++;
      $display("FAIL reset_no_fetch: card_ctrl cycles=%0d required 0", card_cnt - c0);
    end
  endtask

  task automatic test_stay_win();
    int c0, w0;
    c0 = card_cnt;
    w0 = wr_cnt;
    start_game();
    deal(10); deal(9); deal(11); deal(8);
    vectors++;
    if (card_out !== 5'd8) begin
      miscompares++;
      $display("FAIL stay_card_out: got %0d required 8", card_out);
    end
    wait_state(PLAYER_TURN, "stay_reach_turn");
    vectors++;
    if (player_hand !== 5'd20 || dealer_hand !== 5'd17) begin
      miscompares++;
      $display("FAIL stay_hands: player=%0d dealer=%0d required 20/17", player_hand, dealer_hand);
    end
    stay = 1'b1;
    tick();
    stay = 1'b0;
    vectors++;
    if (state_o !== DEALER_TURN || player_action !== STAY) begin
      miscompares++;
      $display("FAIL stay_taken: state=%0d action=%0d required %0d/2", state_o, player_action, DEALER_TURN);
    end
    wait_state(DONE, "stay_reach_done");
    repeat (3) tick();
    vectors++;
    if ({win, lose, tie} !== 3'b100 || dealer_action !== STAY) begin
      miscompares++;
      $display("FAIL stay_outcome: wlt=%b dealer_action=%0d required 100/2", {win, lose, tie}, dealer_action);
    end
    vectors++;
    if (wr_cnt - w0 != 1 || card_cnt - c0 != 4) begin
      miscompares++;
      $display("FAIL stay_strobes: wr pulses=%0d fetches=%0d required 1/4", wr_cnt - w0, card_cnt - c0);
    end
  endtask

  task automatic test_natural();
    int c0;
    start_game();
    c0 = card_cnt;
    deal(1); deal(10); deal(11); deal(7);
    wait_state(DONE, "nat_reach_done");
    tick();
    vectors++;
    if ({win, lose, tie} !== 3'b100 || player_hand !== 5'd21 || dealer_hand !== 5'd17) begin
      miscompares++;
      $display("FAIL natural: wlt=%b player=%0d dealer=%0d required 100/21/17", {win, lose, tie}, player_hand, dealer_hand);
    end
    vectors++;
    if (player_action !== NONE || card_cnt - c0 != 4) begin
      miscompares++;
      $display("FAIL natural_quiet: action=%0d fetches=%0d required 0/4", player_action, card_cnt - c0);
    end
  endtask

  task automatic test_player_bust();
    int c0;
    start_game();
    c0 = card_cnt;
    deal(10); deal(10); deal(6); deal(6);
    wait_state(PLAYER_TURN, "pbust_reach_turn");
    hit = 1'b1;
    tick();
    hit = 1'b0;
    vectors++;
    if (state_o !== PLAYER_HIT || player_action !== HIT) begin
      miscompares++;
      $display("FAIL pbust_hit: state=%0d action=%0d required %0d/1", state_o, player_action, PLAYER_HIT);
    end
    deal(10);
    wait_state(DONE, "pbust_reach_done");
    repeat (2) tick();
    vectors++;
    if (player_hand !== 5'd26 || player_action !== BUST || {win, lose, tie} !== 3'b010) begin
      miscompares++;
      $display("FAIL pbust_result: player=%0d action=%0d wlt=%b required 26/3/010", player_hand, player_action, {win, lose, tie});
    end
    vectors++;
    if (dealer_action !== NONE || dealer_hand !== 5'd16 || card_cnt - c0 != 5) begin
      miscompares++;
      $display("FAIL pbust_dealer_idle: action=%0d dealer=%0d fetches=%0d required 0/16/5", dealer_action, dealer_hand, card_cnt - c0);
    end
  endtask

  task automatic test_dealer_plays();
    start_game();
    deal(10); deal(6); deal(8); deal(5);
    wait_state(PLAYER_TURN, "d21_reach_turn");
    stay = 1'b1;
    tick();
    stay = 1'b0;
    deal(11);
    wait_state(DONE, "d21_reach_done");
    vectors++;
    if (dealer_hand !== 5'd21 || {win, lose, tie} !== 3'b010 || dealer_action !== STAY) begin
      miscompares++;
      $display("FAIL dealer_21: dealer=%0d wlt=%b action=%0d required 21/010/2", dealer_hand, {win, lose, tie}, dealer_action);
    end
    start_game();
    deal(10); deal(6); deal(8); deal(5);
    wait_state(PLAYER_TURN, "dbust_reach_turn");
    stay = 1'b1;
    tick();
    stay = 1'b0;
    deal(5);
    deal(10);
    wait_state(DONE, "dbust_reach_done");
    vectors++;
    if (dealer_hand !== 5'd26 || dealer_action !== BUST || {win, lose, tie} !== 3'b100 || player_hand !== 5'd18) begin
      miscompares++;
      $display("FAIL dealer_bust: dealer=%0d action=%0d wlt=%b player=%0d required 26/3/100/18", dealer_hand, dealer_action, {win, lose, tie}, player_hand);
    end
  endtask

  task automatic test_soft_tie();
    start_game();
    deal(1); deal(10); deal(5); deal(10);
    wait_state(PLAYER_TURN, "soft_reach_turn");
    vectors++;
    if (player_hand !== 5'd16) begin
      miscompares++;
      $display("FAIL soft_total: player=%0d required 16", player_hand);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    deal(10);
    wait_state(PLAYER_TURN, "soft_back_to_turn");
    vectors++;
    if (player_hand !== 5'd16 || player_action !== HIT) begin
      miscompares++;
      $display("FAIL hard_total: player=%0d action=%0d required 16/1", player_hand, player_action);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    deal(4);
    wait_state(PLAYER_TURN, "soft_second_hit");
    stay = 1'b1;
    tick();
    stay = 1'b0;
    wait_state(DONE, "tie_reach_done");
    vectors++;
    if ({win, lose, tie} !== 3'b001 || player_hand !== 5'd20 || dealer_hand !== 5'd20) begin
      miscompares++;
      $display("FAIL tie: wlt=%b player=%0d dealer=%0d required 001/20/20", {win, lose, tie}, player_hand, dealer_hand);
    end
  endtask

  task automatic test_priority_invalid();
    int c0;
    start_game();
    c0 = card_cnt;
    deal(5); deal(6);
    card_in = 5'd0;
    tick();
    vectors++;
    if (state_o !== DEAL_P2 || card_ctrl !== 1'b1 || card_out !== 5'd6 || player_hand !== 5'd5) begin
      miscompares++;
      $display("FAIL invalid_zero: state=%0d card_ctrl=%b card_out=%0d player=%0d required %0d/1/6/5", state_o, card_ctrl, card_out, player_hand, DEAL_P2);
    end
    card_in = 5'd12;
    tick();
    vectors++;
    if (state_o !== DEAL_P2 || player_hand !== 5'd5 || dealer_hand !== 5'd6) begin
      miscompares++;
      $display("FAIL invalid_twelve: state=%0d player=%0d dealer=%0d required %0d/5/6", state_o, player_hand, dealer_hand, DEAL_P2);
    end
    deal(4); deal(1);
    wait_state(PLAYER_TURN, "prio_reach_turn");
    vectors++;
    if (player_hand !== 5'd9 || dealer_hand !== 5'd17) begin
      miscompares++;
      $display("FAIL soft17_deal: player=%0d dealer=%0d required 9/17", player_hand, dealer_hand);
    end
    hit = 1'b1;
    stay = 1'b1;
    tick();
    hit = 1'b0;
    stay = 1'b0;
    vectors++;
    if (state_o !== DEALER_TURN || player_action !== STAY) begin
      miscompares++;
      $display("FAIL stay_priority: state=%0d action=%0d required %0d/2", state_o, player_action, DEALER_TURN);
    end
    wait_state(DONE, "prio_reach_done");
    vectors++;
    if (dealer_action !== STAY || {win, lose, tie} !== 3'b010 || card_cnt - c0 != 6) begin
      miscompares++;
      $display("FAIL soft17_stand: action=%0d wlt=%b fetches=%0d required 2/010/6", dealer_action, {win, lose, tie}, card_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] outs;
    start_game();
    deal(10);
    #2;
    reset = 1'b0;
    #1;
    outs = {card_ctrl, mem_ctrl_rd, mem_ctrl_wr, card_out, player_hand, dealer_hand,
            player_action, dealer_action, win, lose, tie};
    vectors++;
    if (state_o !== IDLE || outs !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_mid: state=%0d outs=%h required %0d/0", state_o, outs, IDLE);
    end
    tick();
    reset = 1'b1;
    repeat (2) tick();
    vectors++;
    if (state_o !== IDLE || card_ctrl !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: state=%0d card_ctrl=%b required %0d/0", state_o, card_ctrl, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_stay_win();
    test_natural();
    test_player_bust();
    test_dealer_plays();
    test_soft_tie();
    test_priority_invalid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
